// File: rtl/sao_pkg.sv
// Shared types and helpers for the SAO LCU scheduler: size encodings, FSM states,
// the latched parameter bundle and LCU edge length.
package sao_pkg;
  localparam int IMG_W = 128;

  localparam logic [1:0] SZ_16  = 2'd0;
  localparam logic [1:0] SZ_32  = 2'd1;
  localparam logic [1:0] SZ_64  = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_PROC, ST_DRAIN, ST_DONE} state_t;

  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  band_pos;
    logic        eo_class;
    logic [15:0] offset;
  } sao_param_t;

  // Reserved size code behaves as 16x16
  function automatic logic [1:0] sz_eff(input logic [1:0] s);
    return (s == SZ_RSV) ? SZ_16 : s;
  endfunction

  function automatic logic [6:0] N_of(input logic [1:0] s);
    return 7'd16 << sz_eff(s);
  endfunction
endpackage

// File: rtl/sao_addr_gen.sv
// Combinational frame address: (lcu_y*N + row)*W + lcu_x*N + col, with LCU indices
// masked to the number of LCUs per frame row.
module sao_addr_gen
  import sao_pkg::*;
#(
  parameter int W = sao_pkg::IMG_W
) (
  input  logic [2:0]  lcu_x,
  input  logic [2:0]  lcu_y,
  input  logic [1:0]  size,
  input  logic [5:0]  row,
  input  logic [5:0]  col,
  output logic [13:0] addr
);
  logic [13:0] n, msk, xs, ys;

  always_comb begin
    n    = 14'(N_of(size));
    msk  = 14'(W / 16 - 1) >> sz_eff(size);
    xs   = {11'd0, lcu_x} & msk;
    ys   = {11'd0, lcu_y} & msk;
    addr = (ys * n + {8'd0, row}) * 14'(W) + xs * n + {8'd0, col};
  end
endmodule

// File: rtl/sao_lcu_sched.sv
// LCU scheduler: fills the LCU buffer from the raster stream, replays it through
// the SAO datapath and emits delayed frame SRAM writes; finish after the last LCU.
module sao_lcu_sched
  import sao_pkg::*;
#(
  parameter int IMG_W = sao_pkg::IMG_W,
  parameter int PIPE  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [2:0]  lcu_x,
  input  logic [2:0]  lcu_y,
  input  logic [1:0]  lcu_size,
  input  logic [1:0]  sao_type,
  input  logic [4:0]  sao_band_pos,
  input  logic        sao_eo_class,
  input  logic [15:0] sao_offset,
  output logic        busy,
  output logic        finish,
  output logic        buf_we,
  output logic [11:0] buf_waddr,
  output logic        buf_re,
  output logic [11:0] buf_raddr,
  output logic [5:0]  cur_row,
  output logic [5:0]  cur_col,
  output logic [1:0]  cur_size,
  output logic [1:0]  p_type,
  output logic [4:0]  p_band_pos,
  output logic        p_eo_class,
  output logic [15:0] p_offset,
  output logic        sram_wen,
  output logic [13:0] sram_addr
);
  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

  state_t              state, nstate;
  sao_param_t          prm;
  logic [2:0]          lx, ly, lcu_m;
  logic [11:0]         fill_cnt, rd_cnt, nn_m1;
  logic [5:0]          row, col, n_m1;
  logic [DW-1:0]       drn_cnt;
  logic                accept, rd_last, drn_last, last_lcu;
  logic [13:0]         rd_addr;
  logic [PIPE:0]       vld_pipe;
  logic [PIPE:0][13:0] addr_pipe;

  always_comb begin
    case (sz_eff(cur_size))
      SZ_32:   nn_m1 = 12'd1023;
      SZ_64:   nn_m1 = 12'd4095;
      default: nn_m1 = 12'd255;
    endcase
  end

  assign n_m1     = 6'(N_of(cur_size) - 7'd1);
  assign lcu_m    = 3'(IMG_W / 16 - 1) >> sz_eff(cur_size);
  assign last_lcu = ((lx & lcu_m) == lcu_m) && ((ly & lcu_m) == lcu_m);
  assign accept   = in_en && !busy && !finish;
  assign rd_last  = (rd_cnt == nn_m1);
  assign drn_last = (drn_cnt == DW'(PIPE - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (accept) nstate = ST_FILL;
      ST_FILL:  if (accept && fill_cnt == nn_m1) nstate = ST_PROC;
      ST_PROC:  if (rd_last) nstate = ST_DRAIN;
      ST_DRAIN: if (drn_last) nstate = last_lcu ? ST_DONE : ST_IDLE;
      default:  nstate = state;
    endcase
  end

  sao_addr_gen #(.W(IMG_W)) u_addr (
    .lcu_x (lx),
    .lcu_y (ly),
    .size  (cur_size),
    .row   (row),
    .col   (col),
    .addr  (rd_addr)
  );

  // vld_pipe[0] is the read strobe; stage PIPE is the matching SRAM write
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      finish    <= 1'b0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_raddr <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      cur_size  <= '0;
      prm       <= '0;
      lx        <= '0;
      ly        <= '0;
      fill_cnt  <= '0;
      rd_cnt    <= '0;
      row       <= '0;
      col       <= '0;
      drn_cnt   <= '0;
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      buf_we    <= 1'b0;
      vld_pipe  <= {vld_pipe[PIPE-1:0], state == ST_PROC};
      addr_pipe <= {addr_pipe[PIPE-1:0], rd_addr};
      case (state)
        ST_IDLE: if (accept) begin
          lx        <= lcu_x;
          ly        <= lcu_y;
          cur_size  <= lcu_size;
          prm       <= {sao_type, sao_band_pos, sao_eo_class, sao_offset};
          buf_we    <= 1'b1;
          buf_waddr <= '0;
          fill_cnt  <= 12'd1;
        end
        ST_FILL: if (accept) begin
          buf_we    <= 1'b1;
          buf_waddr <= fill_cnt;
          fill_cnt  <= fill_cnt + 12'd1;
          if (fill_cnt == nn_m1) begin
            busy     <= 1'b1;
            fill_cnt <= '0;
          end
        end
        ST_PROC: begin
          buf_raddr <= rd_cnt;
          cur_row   <= row;
          cur_col   <= col;
          if (rd_last) begin
            rd_cnt  <= '0;
            row     <= '0;
            col     <= '0;
            drn_cnt <= '0;
          end else begin
            rd_cnt <= rd_cnt + 12'd1;
            if (col == n_m1) begin
              col <= '0;
              row <= row + 6'd1;
            end else begin
              col <= col + 6'd1;
            end
          end
        end
        ST_DRAIN: begin
          drn_cnt <= drn_cnt + DW'(1);
          if (drn_last) begin
            if (last_lcu) finish <= 1'b1;
            else          busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign buf_re     = vld_pipe[0];
  assign sram_wen   = vld_pipe[PIPE];
  assign sram_addr  = addr_pipe[PIPE];
  assign p_type     = prm.typ;
  assign p_band_pos = prm.band_pos;
  assign p_eo_class = prm.eo_class;
  assign p_offset   = prm.offset;
endmodule
